// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan logic.
package seg7_pkg;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Active-low {a,b,c,d,e,f,g} patterns for hex 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/display_scan_controller.sv
// 8-digit seven-segment scan scheduler with per-slot blanking, leading-zero
// suppression and a frame-synchronous double-buffered display value.
module display_scan_controller
  import seg7_pkg::*;
#(
  parameter int DISPLAY_COUNTER = 100000,
  parameter int BLANK_CYCLES    = 16,
  parameter int NUM_DIGITS      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic                    busy,
  output logic                    frame_done,
  output logic [6:0]              segments,
  output logic [7:0]              anodos
);

  localparam int CW = $clog2(DISPLAY_COUNTER);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DISPLAY_COUNTER - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  scan_state_t             state;
  logic [4*NUM_DIGITS-1:0] active, pending;
  logic                    pend_flag;

  logic          slot_end, wrap, lit;
  logic [IW-1:0] msd;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign busy     = pend_flag;

  // Most significant nonzero digit; digit 0 is always kept so zero shows "0".
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (active[4*i +: 4] != 4'h0) msd = IW'(i);
  end

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == IW'(i)) nib = active[4*i +: 4];
  end

  assign lit = digit_mask[idx] && !(lz_blank && (idx > msd));

  seg7_decoder u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= BLANK;
      active     <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
      segments   <= SEG_OFF;
      anodos     <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      case (state)
        BLANK:   if (cnt == BLANK_LAST) state <= DRIVE;
        DRIVE:   if (slot_end) state <= BLANK;
        default: state <= BLANK;
      endcase

      if (state == DRIVE && lit) begin
        anodos   <= ~(8'b1 << idx);
        segments <= dec_seg;
      end else begin
        anodos   <= ANODE_OFF;
        segments <= SEG_OFF;
      end

      frame_done <= wrap;

      // A load landing on the wrap cycle bypasses the pending buffer.
      if (wrap) begin
        if (load)           active <= value_in;
        else if (pend_flag) active <= pending;
        pend_flag <= 1'b0;
      end else if (load) begin
        pending   <= value_in;
        pend_flag <= 1'b1;
      end
    end
  end

endmodule
